// File: rtl/q2_lut_pkg.sv
// Shared constants and types for the 3-input configurable LUT cell.
package q2_lut_pkg;
  localparam int LUT_ADDR_W = 3;
  localparam int LUT_SIZE   = 8;
  localparam logic [LUT_SIZE-1:0] LUT_INIT_DEFAULT = 8'h96;

  typedef logic [LUT_ADDR_W-1:0] lut_addr_t;
  typedef logic [LUT_SIZE-1:0]   lut_table_t;
endpackage

// File: rtl/q2_lut3_if.sv
// Pin bundle of one LUT cell: address/mode pins, serial config chain and output.
interface q2_lut3_if;
  // No handshake: every pin is a level sampled each cycle. cfg_en qualifies
  // cfg_in for one shift per rising edge; OUT and cfg_out are always valid.
  logic A0;
  logic A1;
  logic A2;
  logic A3;
  logic cfg_en;
  logic cfg_in;
  logic cfg_out;
  logic OUT;

  modport master (
    output A0, A1, A2, A3, cfg_en, cfg_in,
    input  cfg_out, OUT
  );

  modport slave (
    input  A0, A1, A2, A3, cfg_en, cfg_in,
    output cfg_out, OUT
  );
endinterface

// File: rtl/lut3_mux.sv
// Purely combinational 8:1 selector: returns bit addr of the truth table.
module lut3_mux
  import q2_lut_pkg::*;
(
  input  lut_table_t tbl,
  input  lut_addr_t  addr,
  output logic       out_bit
);
  assign out_bit = tbl[addr];
endmodule

// File: rtl/q2_lut3.sv
// 3-input LUT cell with serially loaded truth table and a selectable
// combinational or registered output.
module q2_lut3
  import q2_lut_pkg::*;
#(
  parameter lut_table_t INIT = LUT_INIT_DEFAULT
) (
  input logic clk,
  input logic rst,
  q2_lut3_if.slave bus
);
  lut_table_t cfg;
  logic       q;
  lut_addr_t  addr;
  logic       lut_val;

  assign addr = {bus.A2, bus.A1, bus.A0};

  lut3_mux u_mux (
    .tbl     (cfg),
    .addr    (addr),
    .out_bit (lut_val)
  );

  // Reset wins over a concurrent shift; the first bit shifted in ends up in
  // cfg[0] after eight shifts so cells can be daisy-chained via cfg_out.
  always_ff @(posedge clk) begin
    if (rst) begin
      cfg <= INIT;
      q   <= 1'b0;
    end else begin
      if (bus.cfg_en) begin
        cfg <= {bus.cfg_in, cfg[LUT_SIZE-1:1]};
      end
      q <= lut_val;
    end
  end

  assign bus.OUT     = bus.A3 ? q : lut_val;
  assign bus.cfg_out = cfg[0];
endmodule

// File: tb/tb_q2_lut3.sv
// Bench for q2_lut3: reset sweep table, directed corner sequences and
// randomized traffic checked against a behavioural model.
module tb_q2_lut3;
  localparam logic [7:0] INIT_VAL = 8'h96;

  logic clk;
  logic rst;
  int   n_total;
  int   n_pass;

  logic [7:0] m_cfg;
  logic       m_q;

  q2_lut3_if bus ();

  q2_lut3 #(.INIT(INIT_VAL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] a;  // {A3,A2,A1,A0}
    logic       exp_out;
  } vec_t;

  vec_t vecs[16];

  function automatic logic model_lut(input logic [7:0] tbl, input int a);
    return logic'((tbl >> a) & 8'h01);
  endfunction

  function automatic int cur_addr();
    return int'({bus.A2, bus.A1, bus.A0});
  endfunction

  function automatic logic model_out();
    return bus.A3 ? m_q : model_lut(m_cfg, cur_addr());
  endfunction

  task automatic check(input string name, input logic act, input logic exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic set_addr(input int a, input logic a3);
    bus.A0 = a[0];
    bus.A1 = a[1];
    bus.A2 = a[2];
    bus.A3 = a3;
  endtask

  // Advance the model by the rules of one rising edge, then the DUT.
  task automatic tick();
    if (rst) begin
      m_cfg = INIT_VAL;
      m_q   = 1'b0;
    end else begin
      m_q = model_lut(m_cfg, cur_addr());
      if (bus.cfg_en) m_cfg = {bus.cfg_in, m_cfg[7:1]};
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] pat;
    n_total = 0;
    n_pass  = 0;
    m_cfg   = 8'h00;
    m_q     = 1'b0;
    rst        = 1'b1;
    bus.cfg_en = 1'b0;
    bus.cfg_in = 1'b0;
    set_addr(0, 1'b0);

    // Expected outputs while held in reset: parity when combinational, 0 when registered.
    for (int i = 0; i < 16; i++) begin
      vecs[i].a       = 4'(i);
      vecs[i].exp_out = vecs[i].a[3] ? 1'b0 : (vecs[i].a[0] ^ vecs[i].a[1] ^ vecs[i].a[2]);
    end

    tick();
    check("reset_cfg_out", bus.cfg_out, 1'b0);
    for (int i = 0; i < 16; i++) begin
      set_addr(int'(vecs[i].a[2:0]), vecs[i].a[3]);
      #1;
      check($sformatf("reset_sweep[%0d]", i), bus.OUT, vecs[i].exp_out);
    end

    // Registered mode: address change shows up one edge later.
    rst = 1'b0;
    set_addr(0, 1'b1);
    tick();
    check("reg_addr0", bus.OUT, 1'b0);
    set_addr(7, 1'b1);
    #1;
    check("reg_before_edge", bus.OUT, 1'b0);
    tick();
    check("reg_after_edge", bus.OUT, 1'b1);

    // Load majority table 8'hE8 LSB-first.
    pat = 8'hE8;
    bus.cfg_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.cfg_in = pat[i];
      tick();
    end
    bus.cfg_en = 1'b0;
    bus.cfg_in = 1'b0;
    check("maj_cfg_out", bus.cfg_out, 1'b0);
    for (int a = 0; a < 8; a++) begin
      set_addr(a, 1'b0);
      #1;
      check($sformatf("maj_addr%0d", a), bus.OUT,
            logic'((a[0] & a[1]) | (a[0] & a[2]) | (a[1] & a[2])));
    end

    // Reset half way through a reload discards the partial shift.
    bus.cfg_en = 1'b1;
    bus.cfg_in = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.cfg_en = 1'b0;
    bus.cfg_in = 1'b0;
    check("midcfg_rst_cfg_out", bus.cfg_out, 1'b0);
    set_addr(3, 1'b0);
    #1;
    check("midcfg_rst_addr3", bus.OUT, 1'b0);
    set_addr(1, 1'b0);
    #1;
    check("midcfg_rst_addr1", bus.OUT, 1'b1);
    set_addr(1, 1'b1);
    #1;
    check("midcfg_rst_q", bus.OUT, 1'b0);

    // Reset and shift on the same edge: reset wins.
    rst = 1'b1;
    bus.cfg_en = 1'b1;
    bus.cfg_in = 1'b1;
    tick();
    rst = 1'b0;
    bus.cfg_en = 1'b0;
    bus.cfg_in = 1'b0;
    check("rst_prio_cfg_out", bus.cfg_out, 1'b0);
    for (int a = 0; a < 8; a++) begin
      set_addr(a, 1'b0);
      #1;
      check($sformatf("rst_prio_addr%0d", a), bus.OUT, INIT_VAL[a]);
    end

    // A3 toggled between edges only switches the mux.
    set_addr(4, 1'b0);
    tick();
    check("a3_toggle_0", bus.OUT, 1'b1);
    bus.A3 = 1'b1;
    #1;
    check("a3_toggle_1", bus.OUT, 1'b1);
    set_addr(3, 1'b0);
    #1;
    check("a3_addr3_comb", bus.OUT, 1'b0);
    bus.A3 = 1'b1;
    #1;
    check("a3_addr3_reg_hold", bus.OUT, 1'b1);
    tick();
    check("a3_addr3_reg_next", bus.OUT, 1'b0);

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      rst        = ($urandom_range(0, 24) == 0);
      bus.cfg_en = ($urandom_range(0, 3) == 0);
      bus.cfg_in = 1'($urandom_range(0, 1));
      set_addr(int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
      #1;
      check($sformatf("rand_out[%0d]", n), bus.OUT, model_out());
      check($sformatf("rand_cfg_out[%0d]", n), bus.cfg_out, m_cfg[0]);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
